seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
- Controller that sequences a programmable serial-pattern detector.
- Accepts a pattern/length/limit configuration over a valid/ready handshake and arms on `start`.
- Fills a shift window, then reports every (overlapping) match on the `din` bitstream, counts matches, and stops after a programmable match limit.
- Sits between the register/config fabric and the serial input lane.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2).
- CNT_W, 8, width of the match counter and of the limit.

Ports:
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  asynchronous active-low reset
- cfg_valid  input  1  configuration offered
- cfg_ready  output  1  configuration can be accepted (combinational from state)
- cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the earliest-received bit
- cfg_len  input  LEN_W=$clog2(MAX_LEN+1)  pattern length, legal range 1..MAX_LEN
- cfg_limit  input  CNT_W  stop after this many matches; 0 means unlimited
- cfg_err  output  1  one-cycle pulse: illegal cfg_len rejected
- start  input  1  begin detection
- abort  input  1  stop detection, keep configuration
- din_valid  input  1  din is a valid bit this cycle
- din  input  1  serial data bit
- seen  output  1  one-cycle match pulse (registered)
- busy  output  1  state is FILL or RUN
- done  output  1  level: match limit reached
- match_count  output  CNT_W  matches since last start/config, saturating

Behaviour:
- Reset (async, resetn=0): state IDLE; window, fill counter, match_count, seen, done, cfg_err = 0; stored pattern/len/limit = 0. cfg_ready=1 immediately (IDLE).
- States: IDLE, ARMED, FILL, RUN, DONE (enum in package).
- cfg_ready = 1 in IDLE, ARMED, DONE; 0 in FILL, RUN.
- Handshake cfg_valid&cfg_ready, cfg_len in 1..MAX_LEN:
  - latch pattern/len/limit; clear match_count, done, window.
  - next state ARMED.
- Handshake with cfg_len = 0 or > MAX_LEN:
  - no register changes, state unchanged.
  - cfg_err pulses the next cycle.
- ARMED + start: → FILL; window and fill counter cleared.
- DONE + start: → FILL; window and fill counter cleared; match_count and done cleared.
- start in IDLE/FILL/RUN: ignored.
- Priority:
  - abort > cfg handshake > start > din.
  - abort in ARMED/FILL/RUN/DONE → ARMED; clears window, fill counter and done; match_count retained.
  - abort in IDLE: ignored.
  - cfg and start in the same cycle: cfg taken, start dropped.
- Shifting:
  - Only in FILL/RUN with din_valid=1: window <= {window[MAX_LEN-2:0], din}.
  - din_valid=0: no shift, no count, no match.
- FILL:
  - Fill counter increments per valid bit.
  - When the cfg_len-th bit is sampled → RUN; this bit is also match-checked.
  - cfg_len=1 → the first bit is checked.
- Match rule:
  - On a valid-bit edge with fill complete, compare new window[len-1:0] == pattern[len-1:0]; upper bits are don't-care.
  - On a match, seen=1 in the following cycle only.
  - Overlapping matches count, e.g. pattern 101 on 10101 gives 2 matches.
- match_count:
  - +1 per match, registered alongside seen; saturates at 2^CNT_W-1.
  - When limit≠0 and the updated count == limit: → DONE; done=1 (level); no further shifting or matches.
- Latency: the bit sampled at edge N produces seen and an updated match_count visible after edge N, i.e. high for one cycle.
- Reset mid-operation: immediate return to reset values; an in-flight seen pulse is dropped.

Decomposition:
- Package seq_det_pkg:
  - state_t enum (IDLE, ARMED, FILL, RUN, DONE).
  - Default MAX_LEN/CNT_W constants.
  - LEN_W function or localparam helper.
- Sub-module seq_window:
  - MAX_LEN shift register with shift enable and clear.
  - Combinational masked compare against pattern/len.
  - Returns match_next.
- Controller owns the FSM, fill counter, match counter, seen/done registers and handshake.

Test Plan:
- Config 5'b10110, len 5, limit 0; start; stream 1,0,1,1,0,1,1,0 → seen one cycle after bits 5 and 8 (overlap); match_count=2; busy=1 throughout.
- cfg_len=0, then cfg_len=9 with MAX_LEN=8 → cfg_err pulses twice; state stays IDLE; cfg_ready stays 1.
- Pattern 2'b11, len 2, limit 3; stream seven 1s with din_valid gaps → matches on bits 2, 3, 4; then DONE, done=1, match_count=3, further bits ignored; start → match_count=0, FILL.
- Pattern 3'b101 mid-stream: abort after 2 bits → ARMED, no seen; restart with 1,0,1 → seen after third bit (window cleared by abort).
- CNT_W=2, pattern 1'b1, len 1, limit 0; feed six 1s → seen six times; match_count saturates at 3.
- resetn low while RUN and a match is pending → seen=0, match_count=0, state IDLE, cfg_ready=1 without a clock edge.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the serial pattern detector controller.
package seq_det_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StFill,
        StRun,
        StDone
    } state_t;

    localparam int unsigned MaxLenDefault = 8;
    localparam int unsigned CntWDefault   = 8;

    // Width needed to hold a pattern length in 0..max_len.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_window.sv
// Serial shift window with a combinational masked compare on the post-shift contents.
module seq_window #(
    parameter int unsigned MaxLen = 8,
    parameter int unsigned LenW   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic              din_i,
    input  logic [MaxLen-1:0] pattern_i,
    input  logic [LenW-1:0]   len_i,
    output logic              match_o
);

    logic [MaxLen-1:0] window_q, window_d;
    logic [MaxLen-1:0] shifted;
    logic [MaxLen-1:0] mask;

    assign shifted = {window_q[MaxLen-2:0], din_i};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MaxLen; i++) begin
            mask[i] = (LenW'(i) < len_i);
        end
    end

    // Compare what the window will hold once the incoming bit is shifted in.
    assign match_o = (((shifted ^ pattern_i) & mask) == '0);

    always_comb begin
        window_d = window_q;
        if (clr_i) begin
            window_d = '0;
        end else if (shift_i) begin
            window_d = shifted;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequences a programmable serial-pattern detector: config handshake, arm, fill, match, limit.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = MaxLenDefault,
    parameter int unsigned CNT_W   = CntWDefault,
    localparam int unsigned LEN_W  = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_limit,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               din_valid,
    input  logic               din,
    output logic               seen,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_count
);

    state_t state_q, state_d;

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               seen_q, seen_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic             abort_take, cfg_hs, len_ok, cfg_accept, start_take;
    logic             active, shift_en, win_clr, fill_last, check, match_next, hit;
    logic             limit_hit;
    logic [LEN_W-1:0] fill_inc;
    logic [CNT_W-1:0] count_inc;

    assign cfg_ready  = (state_q == StIdle) || (state_q == StArmed) || (state_q == StDone);
    assign active     = (state_q == StFill) || (state_q == StRun);
    assign abort_take = abort && (state_q != StIdle);
    assign cfg_hs     = cfg_valid && cfg_ready && !abort_take;
    assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign cfg_accept = cfg_hs && len_ok;
    // Any handshake, legal or not, claims the cycle and drops a concurrent start.
    assign start_take = start && ((state_q == StArmed) || (state_q == StDone))
                        && !abort_take && !cfg_hs;
    assign shift_en   = active && din_valid && !abort_take;
    assign win_clr    = abort_take || cfg_accept || start_take;

    assign fill_inc   = fill_q + LEN_W'(1);
    assign fill_last  = (state_q == StFill) && (fill_inc == len_q);
    assign check      = shift_en && ((state_q == StRun) || fill_last);
    assign hit        = check && match_next;
    assign count_inc  = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    assign limit_hit  = (limit_q != '0) && (count_inc == limit_q);

    seq_window #(
        .MaxLen (MAX_LEN),
        .LenW   (LEN_W)
    ) u_window (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .clr_i     (win_clr),
        .shift_i   (shift_en),
        .din_i     (din),
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .match_o   (match_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_take || cfg_accept) begin
            state_d = StArmed;
        end else if (start_take) begin
            state_d = StFill;
        end else if (hit && limit_hit) begin
            state_d = StDone;
        end else if (shift_en && fill_last) begin
            state_d = StRun;
        end
    end

    always_comb begin
        busy        = active;
        done        = done_q;
        seen        = seen_q;
        cfg_err     = err_q;
        match_count = count_q;
    end

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        limit_d   = limit_q;
        fill_d    = fill_q;
        count_d   = count_q;
        done_d    = done_q;
        seen_d    = 1'b0;
        err_d     = 1'b0;
        if (abort_take) begin
            fill_d = '0;
            done_d = 1'b0;
        end else if (cfg_hs) begin
            if (len_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                limit_d   = cfg_limit;
                fill_d    = '0;
                count_d   = '0;
                done_d    = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (start_take) begin
            fill_d = '0;
            if (state_q == StDone) begin
                count_d = '0;
                done_d  = 1'b0;
            end
        end else if (shift_en) begin
            if (state_q == StFill) begin
                fill_d = fill_inc;
            end
            if (hit) begin
                seen_d  = 1'b1;
                count_d = count_inc;
                if (limit_hit) begin
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pattern_q <= '0;
            len_q     <= '0;
            limit_q   <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            seen_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            limit_q   <= limit_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            seen_q    <= seen_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule
